seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Downstream display stage for the encoder controller. It consumes the 64-bit, 8-character segment frame (`seg_out`) and drives the board's 8-digit multiplexed seven-segment display.
- The display has two 4-digit groups with separate segment buses (left group: digits 7..4, right group: digits 3..0).
- The block time-multiplexes the digits and snapshots the frame once per refresh cycle to avoid tearing.
- It also blinks a cursor digit to mark the current input position.

Parameters:
- DIGIT_CYCLES, 100000, clock cycles each scan phase is held (1 kHz phase rate at 100 MHz); minimum 2.
- BLINK_FRAMES, 64, number of complete frames per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  display enable; 0 blanks all outputs.
- seg_in  in  64  frame. Byte k = bits [8k+7:8k] is the segment pattern for digit k. Digit 7 is leftmost. Bit=1 means segment lit; bit order {dp,g,f,e,d,c,b,a}.
- cursor_en  in  1  enables blinking of the cursor digit.
- cursor_pos  in  3  index of the digit to blink (0..7).
- an  out  8  digit enables, active-high; an[k] selects digit k.
- seg_l  out  8  segment bus for the left group (digits 7..4), active-high.
- seg_r  out  8  segment bus for the right group (digits 3..0), active-high.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst=1 at a clk edge):
  - presc=0, phase=0, shadow=0, blink_cnt=0, blink_on=0.
  - an=0, seg_l=0, seg_r=0, frame_tick=0.
  - Reset mid-scan aborts immediately; no partial phase is completed.
- Prescaler:
  - presc counts 0..DIGIT_CYCLES-1 and wraps.
  - ptick is asserted combinationally when presc==DIGIT_CYCLES-1.
- Phase counter (2 bits, 0..3):
  - Advances on ptick and wraps 3->0.
  - Phase p drives digit p on the right bus and digit p+4 on the left bus.
- Frame boundary: ptick with phase==3. At this edge:
  - shadow <= seg_in.
  - frame_tick <= 1 for exactly one cycle.
  - blink_cnt is advanced.
- First frame after reset:
  - The cycle immediately after reset deassertion also loads shadow <= seg_in, so the display never shows 0 for a full frame.
  - A one-bit first flag implements this.
- Blink:
  - blink_cnt counts frames 0..BLINK_FRAMES-1.
  - On wrap, blink_on toggles.
  - If cursor_en=1, blink_on=1 and the digit being displayed equals cursor_pos, that digit's segment byte is forced to 0.
  - an stays asserted during this blanking.
- cursor_pos and cursor_en are sampled live each cycle, not snapshotted.
- Output register: an, seg_l and seg_r are registered.
  - Latency is one cycle from a phase change to the output change.
  - an = (1<<phase) | (1<<(phase+4)).
- en=0:
  - an, seg_l and seg_r are 0 on the next edge.
  - presc, phase, shadow, blink and frame_tick keep running, so re-enable resumes without resync.
- Mid-frame seg_in changes are invisible until the next frame boundary. This is required, not optional.
- frame_tick is independent of en.

Decomposition:
- Shared package constants:
  - NUM_DIGITS=8 and DIGITS_PER_GROUP=4.
  - SEG_BLANK=8'h00.
  - Segment bit-position localparams (SEG_A..SEG_DP), which the encoder path also uses.
- Sub-module: seg_scan_timer.
  - Contains the prescaler, phase counter, frame boundary and first-load flag.
  - Outputs ptick, phase[1:0] and frame_boundary.
- The top level holds shadow, blink logic and the output mux/registers.

Test Plan:
1. Reset and first load (DIGIT_CYCLES=4): hold rst 3 cycles with seg_in=64'h0102040810204080; release.
   - During reset: an=0, seg_l=0, seg_r=0.
   - Output holds phase 0 from cycle 2 after release: an=8'h11, seg_r=8'h80, seg_l=8'h08.
2. Scan order: run 16 cycles.
   - an sequence 11,22,44,88, each for 4 cycles, then repeats.
   - frame_tick pulses once per 16 cycles, coincident with the 88->11 transition edge.
3. Tearing guard: change seg_in to all 8'hFF while phase=1.
   - Phases 2 and 3 still show the old bytes.
   - 8'hFF appears on both buses only from the next phase 0.
4. Cursor blink (BLINK_FRAMES=2, cursor_en=1, cursor_pos=5, seg_in all 8'h3F):
   - seg_l reads 8'h00 during phase 1 in frames 2-3, 6-7, ...
   - seg_l reads 8'h3F otherwise; an stays 8'h22 throughout.
5. Enable gating: drop en for 10 cycles, then raise it.
   - Outputs read 0 one cycle after the fall.
   - On re-enable, the phase is presc-consistent (not restarted), verified against a free-running model.
6. Reset mid-phase: assert rst at phase 2, presc=1.
   - Next cycle all outputs are 0 and phase=0.
   - The scan restarts at an=8'h11 after release.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
// Segment bit positions are also used by the encoder that builds the frame.
package seg_scan_driver_pkg;

  localparam int NUM_DIGITS       = 8;
  localparam int DIGITS_PER_GROUP = 4;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [1:0] phase_t;
  typedef logic [2:0] digit_t;

  function automatic logic [7:0] digit_byte(input logic [63:0] frame, input digit_t idx);
    return frame[{idx, 3'b000} +: 8];
  endfunction

  // One digit from each group is lit per phase: digit p on the right, p+4 on the left.
  function automatic logic [7:0] an_mask(input phase_t ph);
    logic [7:0] m;
    m = '0;
    m[{1'b0, ph}] = 1'b1;
    m[{1'b1, ph}] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Frame/cursor inputs and display outputs of the scan driver.
// master = frame source side, slave = the scan driver itself.
interface seg_scan_driver_if;
  import seg_scan_driver_pkg::*;

  logic        en;
  logic [63:0] seg_in;
  logic        cursor_en;
  digit_t      cursor_pos;
  logic [7:0]  an;
  logic [7:0]  seg_l;
  logic [7:0]  seg_r;
  logic        frame_tick;

  modport master (
    output en, seg_in, cursor_en, cursor_pos,
    input  an, seg_l, seg_r, frame_tick
  );

  modport slave (
    input  en, seg_in, cursor_en, cursor_pos,
    output an, seg_l, seg_r, frame_tick
  );

endinterface

// File: rtl/seg_scan_timer.sv
// Scan timebase: digit prescaler, 4-phase counter and frame boundary detection.
// shadow_load also fires once on the first cycle after reset so the frame is captured early.
module seg_scan_timer
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000
) (
  input  logic   clk,
  input  logic   rst,
  output logic   ptick,
  output phase_t phase,
  output logic   frame_boundary,
  output logic   shadow_load
);

  localparam int PW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIGIT_CYCLES - 1);
  localparam phase_t        LAST_PHASE = phase_t'(DIGITS_PER_GROUP - 1);

  logic [PW-1:0] presc;
  logic          first;

  always_comb begin
    ptick          = (presc == PRESC_MAX);
    frame_boundary = ptick && (phase == LAST_PHASE);
    shadow_load    = frame_boundary || first;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      phase <= '0;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      if (ptick) begin
        presc <= '0;
        phase <= phase + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed seven-segment driver: per-frame snapshot of the segment
// frame, blinking cursor digit, and registered digit/segment outputs.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  logic          ptick;
  phase_t        phase;
  logic          frame_boundary;
  logic          shadow_load;

  logic [63:0]   shadow;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  digit_t        dig_r;
  digit_t        dig_l;
  logic [7:0]    seg_r_p0;
  logic [7:0]    seg_l_p0;

  logic [7:0]    an_p1;
  logic [7:0]    seg_l_p1;
  logic [7:0]    seg_r_p1;
  logic          frame_tick_p1;

  seg_scan_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .ptick          (ptick),
    .phase          (phase),
    .frame_boundary (frame_boundary),
    .shadow_load    (shadow_load)
  );

  // Segment select from the frozen shadow; cursor controls are taken live.
  always_comb begin
    dig_r    = {1'b0, phase};
    dig_l    = {1'b1, phase};
    seg_r_p0 = digit_byte(shadow, dig_r);
    seg_l_p0 = digit_byte(shadow, dig_l);
    if (bus.cursor_en && blink_on && (bus.cursor_pos == dig_r)) seg_r_p0 = SEG_BLANK;
    if (bus.cursor_en && blink_on && (bus.cursor_pos == dig_l)) seg_l_p0 = SEG_BLANK;
  end

  // Output stage: en only gates the pins, scanning and snapshotting keep running.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow        <= '0;
      blink_cnt     <= '0;
      blink_on      <= 1'b0;
      frame_tick_p1 <= 1'b0;
      an_p1         <= '0;
      seg_l_p1      <= SEG_BLANK;
      seg_r_p1      <= SEG_BLANK;
    end else begin
      if (shadow_load) shadow <= bus.seg_in;
      if (frame_boundary) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
      frame_tick_p1 <= frame_boundary;
      if (bus.en) begin
        an_p1    <= an_mask(phase);
        seg_l_p1 <= seg_l_p0;
        seg_r_p1 <= seg_r_p0;
      end else begin
        an_p1    <= '0;
        seg_l_p1 <= SEG_BLANK;
        seg_r_p1 <= SEG_BLANK;
      end
    end
  end

  assign bus.an         = an_p1;
  assign bus.seg_l      = seg_l_p1;
  assign bus.seg_r      = seg_r_p1;
  assign bus.frame_tick = frame_tick_p1;

  a_boundary_on_ptick : assert property (@(posedge clk) disable iff (rst) frame_boundary |-> ptick);

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random stimulus checked
// against a cycle-count based reference model.
module tb_seg_scan_driver;

  localparam int DC = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * DC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .DIGIT_CYCLES (DC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: t = clock edges since reset release; everything derives from it.
  int          t = 0;
  logic [63:0] sh = '0;
  logic [7:0]  exp_an = '0;
  logic [7:0]  exp_l = '0;
  logic [7:0]  exp_r = '0;
  logic        exp_ft = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h (t=%0d, time %0t)", tag, obs, exp, t, $time);
  endtask

  function automatic logic blank(input int d, input int bon);
    return bus.cursor_en && (bon != 0) && (int'(bus.cursor_pos) == d);
  endfunction

  task automatic step();
    int ph;
    int bon;
    @(posedge clk);
    if (rst) begin
      exp_an = '0; exp_l = '0; exp_r = '0; exp_ft = 1'b0;
      t = 0; sh = '0;
    end else begin
      ph  = (t / DC) % 4;
      bon = ((t / FRAME) / BF) % 2;
      if (bus.en) begin
        exp_an = 8'((1 << ph) | (1 << (ph + 4)));
        exp_r  = blank(ph, bon)     ? 8'h00 : sh[ph*8 +: 8];
        exp_l  = blank(ph + 4, bon) ? 8'h00 : sh[(ph+4)*8 +: 8];
      end else begin
        exp_an = '0; exp_l = '0; exp_r = '0;
      end
      exp_ft = ((t + 1) % FRAME) == 0;
      if (t == 0 || exp_ft) sh = bus.seg_in;
      t++;
    end
    #1;
    chk("an", 64'(bus.an), 64'(exp_an));
    chk("seg_l", 64'(bus.seg_l), 64'(exp_l));
    chk("seg_r", 64'(bus.seg_r), 64'(exp_r));
    chk("frame_tick", 64'(bus.frame_tick), 64'(exp_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cnt;
    int guard;
    bus.en = 1'b1;
    bus.seg_in = 64'h0102040810204080;
    bus.cursor_en = 1'b0;
    bus.cursor_pos = 3'd0;

    // Reset and first load
    run(3);
    chk("t1_rst_an", 64'(bus.an), 64'h0);
    rst = 1'b0;
    run(2);
    chk("t1_an", 64'(bus.an), 64'h11);
    chk("t1_seg_r", 64'(bus.seg_r), 64'h80);
    chk("t1_seg_l", 64'(bus.seg_l), 64'h08);

    // Scan order, one frame_tick per frame
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (bus.frame_tick) cnt++;
    end
    chk("t2_ft_count", 64'(cnt), 64'd1);

    // Tearing guard: new frame only visible from the next phase 0
    guard = 0;
    while (bus.an !== 8'h22 && guard < 64) begin step(); guard++; end
    chk("t3_reach_ph1", 64'(guard < 64), 64'd1);
    bus.seg_in = {8{8'hFF}};
    guard = 0;
    while (bus.an !== 8'h44 && guard < 64) begin step(); guard++; end
    chk("t3_ph2_old_r", 64'(bus.seg_r), 64'h20);
    guard = 0;
    while (bus.an !== 8'h11 && guard < 64) begin step(); guard++; end
    chk("t3_new_r", 64'(bus.seg_r), 64'hFF);
    chk("t3_new_l", 64'(bus.seg_l), 64'hFF);

    // Cursor blink on digit 5
    bus.seg_in = {8{8'h3F}};
    bus.cursor_en = 1'b1;
    bus.cursor_pos = 3'd5;
    run(8 * FRAME);

    // Enable gating
    bus.en = 1'b0;
    step();
    chk("t5_off_an", 64'(bus.an), 64'h0);
    run(9);
    bus.en = 1'b1;
    run(2 * FRAME);

    // Reset mid-phase (phase 2, presc 1)
    guard = 0;
    while ((t % FRAME) != 9 && guard < 64) begin step(); guard++; end
    rst = 1'b1;
    step();
    chk("t6_rst_an", 64'(bus.an), 64'h0);
    chk("t6_rst_seg_l", 64'(bus.seg_l), 64'h0);
    rst = 1'b0;
    run(2);
    chk("t6_restart_an", 64'(bus.an), 64'h11);
    run(FRAME);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) bus.seg_in = {$urandom, $urandom};
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) bus.cursor_en = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 31) == 0) bus.cursor_pos = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
